prbs_sequencer: RTL and testbench
=================================

// Module: prbs_sequencer
// PURPOSE
//  Sequences the modulator's PRBS generator(s): issues the synchronous reseed, the enable level and a
//  one-cycle valid strobe every OS clocks (symbol rate = clock/OS), and counts symbols for burst or
//  continuous runs. Sits between the top-level control (switches/start/stop) and the PRBS instances;
//  I and Q generators share its strobes.
// PARAMETERS
//  OS      4    clocks per symbol (>=2); valid strobe period
//  LEN_NB  16   width of burst length and symbol counter
// PORTS
//  clock         in   1       system clock, all logic on rising edge
//  i_reset       in   1       synchronous, active-high reset
//  i_enable      in   1       global run enable; low pauses an active run (HOLD)
//  i_start       in   1       one-cycle start request
//  i_stop        in   1       one-cycle abort request
//  i_burst_len   in   LEN_NB  symbols per run, latched on accepted start; 0 = continuous
//  o_prbs_reset  out  1       one-cycle reseed pulse to PRBS i_reset
//  o_prbs_enable out  1       level, high in RUN/HOLD
//  o_prbs_valid  out  1       one-cycle symbol strobe to PRBS i_valid
//  o_busy        out  1       high in SEED/RUN/HOLD
//  o_done        out  1       one-cycle pulse on burst completion
//  o_sym_count   out  LEN_NB  symbols issued in current/last run
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, phase 0, count 0, all outputs 0.
//  - FSM: IDLE, SEED, RUN, HOLD, DONE.
//    IDLE: i_start & !i_stop -> SEED; latch i_burst_len, clear count.
//    SEED: o_prbs_reset=1 for exactly one cycle; phase<=0 -> RUN (or HOLD if !i_enable).
//    RUN : phase counts 0..OS-1, wraps; o_prbs_valid=1 in the cycle phase==OS-1; count+1 same cycle.
//          !i_enable -> HOLD. Burst: valid that makes count==len -> DONE.
//    HOLD: phase and count frozen, no valid; i_enable -> RUN resuming same phase.
//    DONE: o_done=1 one cycle, o_busy=0 -> IDLE. count retained until next start.
//  - Latency: start sampled at cycle t -> o_prbs_reset at t+1 -> RUN from t+2 -> first valid at t+1+OS.
//  - i_stop in SEED/RUN/HOLD -> IDLE next cycle; no o_done, no further valid; count retained.
//  - i_stop and i_start same cycle: stop wins (in IDLE nothing happens).
//  - i_start while busy or in DONE: ignored.
//  - Continuous (len 0): never DONE; o_sym_count wraps 2^LEN_NB-1 -> 0 silently.
//  - i_burst_len changes after start have no effect on the current run.
//  - i_reset mid-run: next cycle IDLE, all outputs 0; PRBS reseed only on next SEED.
// STRUCTURE
//  - prbs_seq_pkg: state localparams (IDLE=0,SEED=1,RUN=2,HOLD=3,DONE=4, 3-bit), default OS/LEN_NB.
//  - Sub-module symbol_tick_gen: phase counter 0..OS-1 with enable/clear, tick output; FSM in top.
//  - Phase counter width $clog2(OS).
// TESTING
//  1 reset, OS=4, len=3, start@t -> prbs_reset @t+1; valid @t+5,t+9,t+13; done @t+14; count=3.
//  2 len=0, enable held -> valid every 4 clocks for 100 symbols, count=100, no done, busy stays 1.
//  3 enable low 10 cycles mid-run after phase 1 -> no valid during HOLD; next valid 2 cycles after resume.
//  4 stop at count=5 -> busy=0 next cycle, no done, count stays 5; start+stop together in IDLE -> no SEED.
//  5 start while RUN ignored; i_burst_len changed mid-run 3->7 -> run ends at 3.
//  6 i_reset during RUN -> all outputs 0 next cycle; LEN_NB=4 continuous -> count wraps 15->0.

Source files
------------

// File: rtl/prbs_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_seq_pkg
//  Purpose  : Shared definitions for the PRBS sequencer: FSM state encoding
//             and default parameter values.
//  Revision : 1.0 - initial release
// ============================================================================
package prbs_seq_pkg;

   localparam int OS_DEFAULT     = 4;   // clocks per symbol
   localparam int LEN_NB_DEFAULT = 16;  // burst length / symbol counter width

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SEED = 3'd1,
      RUN  = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/symbol_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : symbol_tick_gen
//  Purpose  : Symbol phase counter 0..OS-1 with clear/advance control and a
//             registered one-cycle tick for the cycle whose phase is OS-1.
//  Ports    : clock        in  system clock
//             reset        in  synchronous active-high reset
//             clear        in  force phase to 0 for the next cycle
//             advance      in  the current cycle executes a phase (RUN)
//             run_next     in  the next cycle will be a RUN cycle
//             tick_pending out next cycle's phase is OS-1 (combinational)
//             tick         out registered strobe, high in a RUN cycle at OS-1
//  Revision : 1.0 - initial release
// ============================================================================
module symbol_tick_gen #(
   parameter int OS = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   input  logic run_next,
   output logic tick_pending,
   output logic tick
);

   localparam int            PW      = $clog2(OS);
   localparam logic [PW-1:0] PH_LAST = PW'(OS - 1);

   // phase holds the phase the next RUN cycle will execute once a RUN cycle
   // has passed; during HOLD it is frozen so the run resumes where it stopped.
   logic [PW-1:0] phase;
   logic [PW-1:0] phase_next;

   always_comb begin
      phase_next = phase;
      if (clear) begin
         phase_next = '0;
      end else if (advance) begin
         phase_next = (phase == PH_LAST) ? '0 : phase + 1'b1;
      end
   end

   assign tick_pending = (phase_next == PH_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         phase <= '0;
         tick  <= 1'b0;
      end else begin
         phase <= phase_next;
         tick  <= run_next & tick_pending;
      end
   end

endmodule
`default_nettype wire

// File: rtl/prbs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_sequencer
//  Purpose  : Sequences the PRBS generator(s): reseed pulse, enable level and
//             a valid strobe every OS clocks; counts symbols for burst
//             (i_burst_len > 0) or continuous (i_burst_len == 0) runs.
//  Ports    : clock         in  system clock
//             i_reset       in  synchronous active-high reset
//             i_enable      in  run enable; low pauses an active run
//             i_start       in  one-cycle start request
//             i_stop        in  one-cycle abort request
//             i_burst_len   in  symbols per run, latched on accepted start
//             o_prbs_reset  out one-cycle reseed pulse
//             o_prbs_enable out high in RUN/HOLD
//             o_prbs_valid  out one-cycle symbol strobe
//             o_busy        out high in SEED/RUN/HOLD
//             o_done        out one-cycle burst completion pulse
//             o_sym_count   out symbols issued in current/last run
//  Revision : 1.0 - initial release
// ============================================================================
module prbs_sequencer
   import prbs_seq_pkg::*;
#(
   parameter int OS     = OS_DEFAULT,
   parameter int LEN_NB = LEN_NB_DEFAULT
) (
   input  logic              clock,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_start,
   input  logic              i_stop,
   input  logic [LEN_NB-1:0] i_burst_len,
   output logic              o_prbs_reset,
   output logic              o_prbs_enable,
   output logic              o_prbs_valid,
   output logic              o_busy,
   output logic              o_done,
   output logic [LEN_NB-1:0] o_sym_count
);

   state_t            state;
   state_t            next_state;
   logic [LEN_NB-1:0] burst_len;
   logic              tick_pending;
   logic              run_next;
   logic              count_inc;
   logic              last_symbol;

   // The symbol that completes a burst is the one strobed in this cycle
   // (o_sym_count already includes it).
   assign last_symbol = o_prbs_valid && (burst_len != '0) && (o_sym_count == burst_len);

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (i_start && !i_stop) next_state = SEED;
         end
         SEED: begin
            if (i_stop)         next_state = IDLE;
            else if (!i_enable) next_state = HOLD;
            else                next_state = RUN;
         end
         RUN: begin
            if (i_stop)           next_state = IDLE;
            else if (last_symbol) next_state = DONE;
            else if (!i_enable)   next_state = HOLD;
         end
         HOLD: begin
            if (i_stop)        next_state = IDLE;
            else if (i_enable) next_state = RUN;
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign run_next  = (next_state == RUN);
   assign count_inc = run_next && tick_pending;

   symbol_tick_gen #(
      .OS (OS)
   ) u_tick (
      .clock        (clock),
      .reset        (i_reset),
      .clear        ((state != RUN) && (state != HOLD)),
      .advance      (state == RUN),
      .run_next     (run_next),
      .tick_pending (tick_pending),
      .tick         (o_prbs_valid)
   );

   // Outputs are registered from the next-state decode so each one lines up
   // with the cycle its state is current.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state         <= IDLE;
         burst_len     <= '0;
         o_prbs_reset  <= 1'b0;
         o_prbs_enable <= 1'b0;
         o_busy        <= 1'b0;
         o_done        <= 1'b0;
         o_sym_count   <= '0;
      end else begin
         state         <= next_state;
         o_prbs_reset  <= (next_state == SEED);
         o_prbs_enable <= (next_state == RUN) || (next_state == HOLD);
         o_busy        <= (next_state == SEED) || (next_state == RUN) || (next_state == HOLD);
         o_done        <= (next_state == DONE);
         if ((state == IDLE) && (next_state == SEED)) begin
            burst_len   <= i_burst_len;
            o_sym_count <= '0;
         end else if (count_inc) begin
            o_sym_count <= o_sym_count + 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_prbs_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_sequencer
//  Purpose  : Directed self-checking bench for prbs_sequencer (OS=4), with a
//             second LEN_NB=4 instance for counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prbs_sequencer;

   logic        clk;
   logic        rst, en, start, stop;
   logic [15:0] len;
   logic        prbs_reset, prbs_enable, prbs_valid, busy, done;
   logic [15:0] count;

   logic        rst_b, en_b, start_b, stop_b;
   logic [3:0]  len_b;
   logic        prbs_reset_b, prbs_enable_b, prbs_valid_b, busy_b, done_b;
   logic [3:0]  count_b;

   int errors = 0;
   int checks = 0;

   prbs_sequencer #(.OS(4), .LEN_NB(16)) dut (
      .clock(clk), .i_reset(rst), .i_enable(en), .i_start(start), .i_stop(stop),
      .i_burst_len(len), .o_prbs_reset(prbs_reset), .o_prbs_enable(prbs_enable),
      .o_prbs_valid(prbs_valid), .o_busy(busy), .o_done(done), .o_sym_count(count)
   );

   prbs_sequencer #(.OS(4), .LEN_NB(4)) dut_b (
      .clock(clk), .i_reset(rst_b), .i_enable(en_b), .i_start(start_b), .i_stop(stop_b),
      .i_burst_len(len_b), .o_prbs_reset(prbs_reset_b), .o_prbs_enable(prbs_enable_b),
      .o_prbs_valid(prbs_valid_b), .o_busy(busy_b), .o_done(done_b), .o_sym_count(count_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs are driven and outputs sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_b = 1'b1;
      step(); step();
      checks++;
      if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== 5'b0 || count !== 16'd0) begin
         errors++;
         $display("FAIL reset_a got ctl=%b cnt=%0d required ctl=00000 cnt=0",
                  {prbs_reset, prbs_enable, prbs_valid, busy, done}, count);
      end
      checks++;
      if ({prbs_reset_b, prbs_enable_b, prbs_valid_b, busy_b, done_b} !== 5'b0 || count_b !== 4'd0) begin
         errors++;
         $display("FAIL reset_b got ctl=%b cnt=%0d required ctl=00000 cnt=0",
                  {prbs_reset_b, prbs_enable_b, prbs_valid_b, busy_b, done_b}, count_b);
      end
      rst = 1'b0; rst_b = 1'b0;
      step();
   endtask

   // len=3 burst: reseed k=1, valid k=5,9,13, done k=14 (k = cycles after start).
   // With mid_change, a second start and a new length are applied at k=3.
   task automatic test_burst(input bit mid_change);
      logic [4:0]  exp_v;
      logic [15:0] exp_cnt;
      en = 1'b1; len = 16'd3; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (mid_change) begin
            start = (k == 3);
            if (k == 3) len = 16'd7;
         end
         exp_v   = {k == 1, (k >= 2 && k <= 13), (k == 5 || k == 9 || k == 13), (k <= 13), k == 14};
         exp_cnt = 16'd0;
         if (k >= 5)  exp_cnt = 16'd1;
         if (k >= 9)  exp_cnt = 16'd2;
         if (k >= 13) exp_cnt = 16'd3;
         checks++;
         if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== exp_v) begin
            errors++;
            $display("FAIL burst_ctl(mid=%0d) k=%0d got=%b required=%b", mid_change, k,
                     {prbs_reset, prbs_enable, prbs_valid, busy, done}, exp_v);
         end
         checks++;
         if (count !== exp_cnt) begin
            errors++;
            $display("FAIL burst_cnt(mid=%0d) k=%0d got=%0d required=%0d", mid_change, k, count, exp_cnt);
         end
         step();
      end
      start = 1'b0; len = 16'd0;
   endtask

   task automatic test_continuous();
      logic [4:0] exp_v;
      en = 1'b1; len = 16'd0; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 404; k++) begin
         exp_v = {k == 1, k >= 2, (k >= 5) && ((k - 5) % 4 == 0), 1'b1, 1'b0};
         checks++;
         if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== exp_v) begin
            errors++;
            $display("FAIL cont_ctl k=%0d got=%b required=%b", k,
                     {prbs_reset, prbs_enable, prbs_valid, busy, done}, exp_v);
         end
         if (k < 404) step();
      end
      checks++;
      if (count !== 16'd100) begin
         errors++;
         $display("FAIL cont_count got=%0d required=100", count);
      end
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if ({prbs_enable, prbs_valid, busy, done} !== 4'b0 || count !== 16'd100) begin
         errors++;
         $display("FAIL cont_stop got ctl=%b cnt=%0d required ctl=0000 cnt=100",
                  {prbs_enable, prbs_valid, busy, done}, count);
      end
      step();
   endtask

   // Enable drops in the phase-1 cycle (k=3) for 10 cycles; raised at k=13,
   // the held phase 2 runs at k=14 and the strobe lands at k=15.
   task automatic test_hold();
      logic [15:0] exp_cnt;
      len = 16'd0; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         en = !(k >= 3 && k <= 12);
         exp_cnt = 16'd0;
         if (k >= 15) exp_cnt = 16'd1;
         if (k >= 19) exp_cnt = 16'd2;
         checks++;
         if (prbs_valid !== (k == 15 || k == 19) || busy !== 1'b1 || prbs_enable !== (k >= 2)) begin
            errors++;
            $display("FAIL hold_ctl k=%0d got valid=%b busy=%b en=%b required valid=%b busy=1 en=%b",
                     k, prbs_valid, busy, prbs_enable, (k == 15 || k == 19), (k >= 2));
         end
         checks++;
         if (count !== exp_cnt) begin
            errors++;
            $display("FAIL hold_cnt k=%0d got=%0d required=%0d", k, count, exp_cnt);
         end
         step();
      end
      en = 1'b1; stop = 1'b1;
      step();
      stop = 1'b0;
      step();
   endtask

   task automatic test_stop();
      len = 16'd10; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (20) step();
      checks++;
      if (prbs_valid !== 1'b1 || count !== 16'd5) begin
         errors++;
         $display("FAIL stop_pre got valid=%b cnt=%0d required valid=1 cnt=5", prbs_valid, count);
      end
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== 5'b0 || count !== 16'd5) begin
            errors++;
            $display("FAIL stop_after k=%0d got ctl=%b cnt=%0d required ctl=00000 cnt=5", k,
                     {prbs_reset, prbs_enable, prbs_valid, busy, done}, count);
         end
         step();
      end
      start = 1'b1; stop = 1'b1;
      step();
      start = 1'b0; stop = 1'b0;
      for (int k = 0; k < 6; k++) begin
         checks++;
         if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== 5'b0 || count !== 16'd5) begin
            errors++;
            $display("FAIL start_stop_idle k=%0d got ctl=%b cnt=%0d required ctl=00000 cnt=5", k,
                     {prbs_reset, prbs_enable, prbs_valid, busy, done}, count);
         end
         step();
      end
   endtask

   task automatic test_reset_and_wrap();
      len = 16'd0; en = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      checks++;
      if (busy !== 1'b1 || count !== 16'd1) begin
         errors++;
         $display("FAIL midrun_pre got busy=%b cnt=%0d required busy=1 cnt=1", busy, count);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({prbs_reset, prbs_enable, prbs_valid, busy, done} !== 5'b0 || count !== 16'd0) begin
            errors++;
            $display("FAIL midrun_reset k=%0d got ctl=%b cnt=%0d required ctl=00000 cnt=0", k,
                     {prbs_reset, prbs_enable, prbs_valid, busy, done}, count);
         end
         step();
      end

      len_b = 4'd0; en_b = 1'b1; start_b = 1'b1;
      step();
      start_b = 1'b0;
      repeat (60) step();
      checks++;
      if (prbs_valid_b !== 1'b1 || count_b !== 4'd15) begin
         errors++;
         $display("FAIL wrap_15 got valid=%b cnt=%0d required valid=1 cnt=15", prbs_valid_b, count_b);
      end
      repeat (4) step();
      checks++;
      if ({prbs_reset_b, prbs_enable_b, prbs_valid_b, busy_b, done_b} !== 5'b01110 || count_b !== 4'd0) begin
         errors++;
         $display("FAIL wrap_0 got ctl=%b cnt=%0d required ctl=01110 cnt=0",
                  {prbs_reset_b, prbs_enable_b, prbs_valid_b, busy_b, done_b}, count_b);
      end
      stop_b = 1'b1;
      step();
      stop_b = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0; len = 16'd0;
      rst_b = 1'b1; en_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; len_b = 4'd0;
      test_reset();
      test_burst(1'b0);
      test_continuous();
      test_hold();
      test_stop();
      test_burst(1'b1);
      test_reset_and_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
